// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two requesters. Each requester
//   offers an operation over valid/ready. The block grants one of them
//   round-robin and drives the ALU from registered operands. It holds those
//   operands for ALU_LATENCY cycles, then samples the result into a single
//   response channel tagged with the requester id.
//
//   Optional feature macro: ALU_SHARE_STATS_EN
//     When defined, adds 8-bit grant counters grant_cnt0/grant_cnt1.
//     Each counter counts the handshakes of its requester and wraps 255->0.
//
// Ports
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   req{0,1}_valid/ready            request handshake (ready is combinational)
//   req{0,1}_a/_b/_mode/_c_in       request operands, mode (00 add, 01 sub, 10 xor, 11 and), carry-in
//   rsp_valid/rsp_ready             response handshake
//   rsp_id/rsp_result/rsp_c_out     response payload (c_out forced 0 for logic modes)
//   alu_a/alu_b/alu_mode/alu_c_in   registered drive to the shared ALU
//   alu_result/alu_c_out            ALU outputs
//   busy                            high whenever the arbiter is not idle
//   grant_cnt0/grant_cnt1           per-requester grant counters (ALU_SHARE_STATS_EN only)

module alu_share_arbiter #(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_mode,
    input  logic             req0_c_in,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_mode,
    input  logic             req1_c_in,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_c_out,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_mode,
    output logic             alu_c_in,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_c_out,

    output logic             busy
`ifdef ALU_SHARE_STATS_EN
    ,
    output logic [7:0]       grant_cnt0,
    output logic [7:0]       grant_cnt1
`endif
);

    // Settle counter only has to reach ALU_LATENCY-1.
    localparam int unsigned CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             grant_sel;
    logic             accept;
    logic             capture;
    logic             release_rsp;
    logic [CNT_W-1:0] cnt;

    // Round-robin pick: the lone valid requester, or the one not granted last.
    always_comb begin
        grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant;
        end else if (req1_valid) begin
            grant_sel = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake readys and datapath strobes.
    always_comb begin
        state_next  = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        release_rsp = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = req0_valid && !grant_sel;
                req1_ready = req1_valid &&  grant_sel;
                if (req0_ready || req1_ready) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt == CNT_LAST) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                // Returning to IDLE costs a cycle, so no accept overlaps the response handshake.
                if (rsp_ready) begin
                    release_rsp = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ALU drive registers: loaded only on acceptance, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_mode   <= 2'b00;
            alu_c_in   <= 1'b0;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
        end else if (accept) begin
            alu_a      <= grant_sel ? req1_a    : req0_a;
            alu_b      <= grant_sel ? req1_b    : req0_b;
            alu_mode   <= grant_sel ? req1_mode : req0_mode;
            alu_c_in   <= grant_sel ? req1_c_in : req0_c_in;
            last_grant <= grant_sel;
            rsp_id     <= grant_sel;
        end
    end

    // Settle counter: cleared on accept, counts while the ALU inputs are held.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == EXEC) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Response registers: sampled once from the ALU, held until consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_c_out  <= 1'b0;
        end else if (capture) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_c_out  <= alu_c_out & ~alu_mode[1];
        end else if (release_rsp) begin
            rsp_valid  <= 1'b0;
        end
    end

    // Registered busy flag tracks the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
        end
    end

`ifdef ALU_SHARE_STATS_EN
    // Per-requester grant counters, wrapping naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0 <= 8'd0;
            grant_cnt1 <= 8'd0;
        end else begin
            if (req0_ready) begin
                grant_cnt0 <= grant_cnt0 + 8'd1;
            end
            if (req1_ready) begin
                grant_cnt1 <= grant_cnt1 + 8'd1;
            end
        end
    end
`endif

endmodule
